reg_writeback: RTL
==================

// Module: reg_writeback
// PURPOSE
//  Writeback stage directly upstream of the 16x16-bit register file. Accepts results from
//  the ALU and memory-load channels via valid/ready, registers them, and drives the two
//  register-file write ports (D port: ALU, S port: load). Keeps a pending-load scoreboard
//  that decode uses for hazard stalls, and resolves same-register write collisions.
// PARAMETERS
//  DW   16  data width of results and register-file write data
//  AW   4   register address width (2**AW registers)
//  CW   8   width of saturating collision counter
// PORTS
//  Clock        in   1    single clock; all state updates on rising edge
//  Reset        in   1    synchronous, active-high reset
//  alu_valid    in   1    ALU result present
//  alu_ready    out  1    ALU result accepted when alu_valid & alu_ready at rising edge
//  alu_addr     in   AW   ALU destination register
//  alu_data     in   DW   ALU result
//  ld_valid     in   1    load result present
//  ld_ready     out  1    load result accepted when ld_valid & ld_ready at rising edge
//  ld_addr      in   AW   load destination register
//  ld_data      in   DW   load data
//  rsv_valid    in   1    decode issues a load: reserve rsv_addr in scoreboard
//  rsv_addr     in   AW   register being reserved
//  wb_hold      in   1    register-file write ports unavailable this cycle
//  wr_d_en      out  1    D-port write enable (to register file Rd_Wen)
//  wr_d_addr    out  AW   D-port write address
//  wr_d_data    out  DW   D-port write data
//  wr_s_en      out  1    S-port write enable (to register file Rs_Wen)
//  wr_s_addr    out  AW   S-port write address
//  wr_s_data    out  DW   S-port write data
//  pending      out  2**AW  scoreboard: bit n = load to Rn in flight
//  collisions   out  CW   count of elided ALU writes, saturates at all-ones
// BEHAVIOUR
//  Reset: both stage registers invalid; wr_*_en=0, wr_*_addr=0, wr_*_data=0; pending=0;
//   collisions=0; alu_ready=ld_ready=1 in the first cycle after reset.
//  Stage: one holding register per channel (a_v/a_addr/a_data, l_v/l_addr/l_data).
//   ready = ~stage_v | ~wb_hold (combinational). Accept loads stage register; if stage
//   valid and not held and no new accept, stage goes invalid after the write cycle.
//  Output: wr_d_en = a_v & ~wb_hold & ~collide; wr_s_en = l_v & ~wb_hold. addr/data
//   outputs always reflect stage registers (don't-care when en=0).
//  Latency: result accepted at edge N -> write enable high in cycle N..N+1 ->
//   register file commits at edge N+1 (one cycle accept-to-commit) when wb_hold=0.
//  wb_hold=1: both enables 0, stage contents held, ready low for each valid stage.
//  Collision: collide = a_v & l_v & (a_addr==l_addr). Decode never issues an op whose
//   destination is pending, so the ALU result is older; load wins. ALU write is elided
//   (stage consumed, wr_d_en=0), collisions += 1 (saturating) on that edge if not held.
//  Scoreboard, evaluated per edge:
//   - clear bit l_addr when wr_s_en=1;
//   - set bit rsv_addr when rsv_valid=1;
//   - same bit cleared and set on one edge -> stays set (new load wins);
//   - rsv to already-pending bit: remains set (decode contract violation, no error).
//  Reset mid-operation: stage data discarded, no write issued, pending cleared.
// TESTING
//  1 Reset, then alu_valid=1 addr=3 data=0x1234 -> next cycle wr_d_en=1 addr=3
//    data=0x1234, wr_s_en=0; cycle after, wr_d_en=0.
//  2 rsv_valid addr=7 -> pending=0x0080; ld addr=7 data=0xBEEF accepted -> wr_s_en=1
//    addr=7 data=0xBEEF, pending=0x0000 after that edge.
//  3 ALU and load both to R5 same cycle (0x1111 / 0x2222) -> wr_s_en=1 data=0x2222,
//    wr_d_en=0, collisions=1; ALU and load to R5/R6 -> both enables 1, no count.
//  4 wb_hold=1 for 3 cycles with both stages valid -> enables 0, ready=0, data stable;
//    hold released -> both writes issue next cycle with original data.
//  5 Reset asserted while both stages valid and pending=0x00F0 -> next cycle enables 0,
//    pending=0, readies 1; collision counter driven to 255 then one more -> stays 255.
//  6 Same edge: wr_s_en clears R9 and rsv_valid reserves R9 -> pending bit 9 stays 1.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback stage feeding the two register-file write ports (D: ALU, S: load).
// It holds a pending-load scoreboard and gives the load priority on same-register collisions.
module reg_writeback #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DW-1:0]     alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              wb_hold,
  output logic              wr_d_en,
  output logic [AW-1:0]     wr_d_addr,
  output logic [DW-1:0]     wr_d_data,
  output logic              wr_s_en,
  output logic [AW-1:0]     wr_s_addr,
  output logic [DW-1:0]     wr_s_data,
  output logic [2**AW-1:0]  pending,
  output logic [CW-1:0]     collisions
);

  localparam int unsigned NREG = 2**AW;

  logic            a_v, l_v;
  logic [AW-1:0]   a_addr, l_addr;
  logic [DW-1:0]   a_data, l_data;
  logic            collide;
  logic            alu_acc, ld_acc;
  logic [NREG-1:0] pend_clr, pend_set, pend_nxt;

  assign alu_ready = ~a_v | ~wb_hold;
  assign ld_ready  = ~l_v | ~wb_hold;
  assign alu_acc   = alu_valid & alu_ready;
  assign ld_acc    = ld_valid & ld_ready;

  // The ALU result is always older than a colliding load, so the load wins.
  assign collide = a_v & l_v & (a_addr == l_addr);

  assign wr_d_en   = a_v & ~wb_hold & ~collide;
  assign wr_d_addr = a_addr;
  assign wr_d_data = a_data;
  assign wr_s_en   = l_v & ~wb_hold;
  assign wr_s_addr = l_addr;
  assign wr_s_data = l_data;

  // A reservation on the same edge as its clear wins, because it belongs to a newer load.
  always_comb begin
    pend_clr = '0;
    pend_set = '0;
    if (wr_s_en)   pend_clr[l_addr]   = 1'b1;
    if (rsv_valid) pend_set[rsv_addr] = 1'b1;
    pend_nxt = (pending & ~pend_clr) | pend_set;
  end

  // ALU stage register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_v    <= 1'b0;
      a_addr <= '0;
      a_data <= '0;
    end else if (alu_acc) begin
      a_v    <= 1'b1;
      a_addr <= alu_addr;
      a_data <= alu_data;
    end else if (a_v && !wb_hold) begin
      a_v    <= 1'b0;
    end
  end

  // Load stage register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      l_v    <= 1'b0;
      l_addr <= '0;
      l_data <= '0;
    end else if (ld_acc) begin
      l_v    <= 1'b1;
      l_addr <= ld_addr;
      l_data <= ld_data;
    end else if (l_v && !wb_hold) begin
      l_v    <= 1'b0;
    end
  end

  // Scoreboard and saturating collision counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending    <= '0;
      collisions <= '0;
    end else begin
      pending <= pend_nxt;
      if (collide && !wb_hold && !(&collisions))
        collisions <= collisions + CW'(1);
    end
  end

endmodule
